// File: rtl/etapa_id_ex_pkg.sv
// Shared widths and encodings for the ID/EX boundary stage.
`timescale 1ns/1ps
package etapa_id_ex_pkg;

  localparam int BITS_REGISTROS = 32;
  localparam int BITS_ADDRESS   = 5;
  localparam int BITS_CONTADOR  = 16;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  typedef enum logic {
    RUN     = 1'b0,
    BURBUJA = 1'b1
  } estado_e;

endpackage

// File: rtl/etapa_id_ex_selector_forwarding.sv
// One operand's forwarding network: source match, EX>MEM>WB>RF priority and data mux.
// With FORWARDING_EN undefined every match becomes a hazard and the register file is always used.
`timescale 1ns/1ps
module selector_forwarding
  import etapa_id_ex_pkg::*;
#(
  parameter int CANTIDAD_BITS_REGISTROS         = BITS_REGISTROS,
  parameter int CANTIDAD_BITS_ADDRESS_REGISTROS = BITS_ADDRESS
) (
  input  logic                                       lee,
  input  logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] fuente,
  input  logic [CANTIDAD_BITS_REGISTROS-1:0]         data_rf,
  input  logic                                       ex_reg_write,
  input  logic                                       ex_mem_read,
  input  logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] ex_rd,
  input  logic [CANTIDAD_BITS_REGISTROS-1:0]         ex_data,
  input  logic                                       mem_reg_write,
  input  logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] mem_rd,
  input  logic [CANTIDAD_BITS_REGISTROS-1:0]         mem_data,
  input  logic                                       wb_reg_write,
  input  logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] wb_rd,
  input  logic [CANTIDAD_BITS_REGISTROS-1:0]         wb_data,
  output logic [CANTIDAD_BITS_REGISTROS-1:0]         data,
  output logic                                       riesgo
);

  logic     fuente_valida;
  logic     match_ex;
  logic     carga_en_ex;
  logic     alu_en_ex;
  logic     match_mem;
  logic     match_wb;
  fwd_sel_e seleccion;

  // Register 0 is hardwired, so it never matches a producer.
  assign fuente_valida = (fuente != '0);
  assign match_ex      = fuente_valida && ex_reg_write  && (ex_rd  == fuente);
  assign match_mem     = fuente_valida && mem_reg_write && (mem_rd == fuente);
  assign match_wb      = fuente_valida && wb_reg_write  && (wb_rd  == fuente);
  assign carga_en_ex   = match_ex &&  ex_mem_read;
  assign alu_en_ex     = match_ex && !ex_mem_read;

`ifdef FORWARDING_EN
  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    seleccion = FWD_RF;
    if (alu_en_ex)      seleccion = FWD_EX;
    else if (match_mem) seleccion = FWD_MEM;
    else if (match_wb)  seleccion = FWD_WB;
  end

  // Load data only exists after MEM, so a load in EX can only be waited out.
  assign riesgo = lee && carga_en_ex;
`else
  assign seleccion = FWD_RF;
  assign riesgo    = lee && (carga_en_ex || alu_en_ex || match_mem || match_wb);
`endif

  always_comb begin
    data = data_rf;
    case (seleccion)
      FWD_EX:  data = ex_data;
      FWD_MEM: data = mem_data;
      FWD_WB:  data = wb_data;
      default: data = data_rf;
    endcase
  end

endmodule

// File: rtl/etapa_id_ex.sv
// ID/EX boundary stage: operand forwarding, load-use stall FSM, ID/EX latch, bubble counter.
// Build option FORWARDING_EN enables the EX/MEM/WB bypass; without it every RAW match stalls.
`timescale 1ns/1ps
module etapa_id_ex
  import etapa_id_ex_pkg::*;
#(
  parameter int CANTIDAD_BITS_REGISTROS         = BITS_REGISTROS,
  parameter int CANTIDAD_BITS_ADDRESS_REGISTROS = BITS_ADDRESS,
  parameter int CANTIDAD_BITS_CONTADOR          = BITS_CONTADOR
) (
  input  logic                                       i_clock,
  input  logic                                       i_soft_reset,
  input  logic                                       i_enable_etapa,
  input  logic                                       i_valid,
  input  logic                                       i_flush,
  input  logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] i_rs,
  input  logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] i_rt,
  input  logic                                       i_uses_rt,
  input  logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] i_rd,
  input  logic                                       i_reg_write,
  input  logic                                       i_mem_read,
  input  logic [CANTIDAD_BITS_REGISTROS-1:0]         i_data_A,
  input  logic [CANTIDAD_BITS_REGISTROS-1:0]         i_data_B,
  input  logic [CANTIDAD_BITS_REGISTROS-1:0]         i_imm,
  input  logic                                       i_ex_reg_write,
  input  logic                                       i_ex_mem_read,
  input  logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] i_ex_rd,
  input  logic [CANTIDAD_BITS_REGISTROS-1:0]         i_ex_data,
  input  logic                                       i_mem_reg_write,
  input  logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] i_mem_rd,
  input  logic [CANTIDAD_BITS_REGISTROS-1:0]         i_mem_data,
  input  logic                                       i_wb_reg_write,
  input  logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] i_wb_rd,
  input  logic [CANTIDAD_BITS_REGISTROS-1:0]         i_wb_data,
  output logic                                       o_stall,
  output logic                                       o_valid,
  output logic                                       o_reg_write,
  output logic                                       o_mem_read,
  output logic [CANTIDAD_BITS_ADDRESS_REGISTROS-1:0] o_rd,
  output logic [CANTIDAD_BITS_REGISTROS-1:0]         o_data_A,
  output logic [CANTIDAD_BITS_REGISTROS-1:0]         o_data_B,
  output logic [CANTIDAD_BITS_REGISTROS-1:0]         o_imm,
  output logic [CANTIDAD_BITS_CONTADOR-1:0]          o_contador_burbujas
);

  estado_e                          estado;
  estado_e                          estado_siguiente;
  logic [CANTIDAD_BITS_REGISTROS-1:0] dato_A;
  logic [CANTIDAD_BITS_REGISTROS-1:0] dato_B;
  logic                             riesgo_A;
  logic                             riesgo_B;
  logic                             riesgo;
  logic                             inserta_burbuja;
  logic                             carga_instr;
  logic                             cuenta_burbuja;

  selector_forwarding #(
    .CANTIDAD_BITS_REGISTROS        (CANTIDAD_BITS_REGISTROS),
    .CANTIDAD_BITS_ADDRESS_REGISTROS(CANTIDAD_BITS_ADDRESS_REGISTROS)
  ) u_forwarding_A (
    .lee          (i_valid),
    .fuente       (i_rs),
    .data_rf      (i_data_A),
    .ex_reg_write (i_ex_reg_write),
    .ex_mem_read  (i_ex_mem_read),
    .ex_rd        (i_ex_rd),
    .ex_data      (i_ex_data),
    .mem_reg_write(i_mem_reg_write),
    .mem_rd       (i_mem_rd),
    .mem_data     (i_mem_data),
    .wb_reg_write (i_wb_reg_write),
    .wb_rd        (i_wb_rd),
    .wb_data      (i_wb_data),
    .data         (dato_A),
    .riesgo       (riesgo_A)
  );

  selector_forwarding #(
    .CANTIDAD_BITS_REGISTROS        (CANTIDAD_BITS_REGISTROS),
    .CANTIDAD_BITS_ADDRESS_REGISTROS(CANTIDAD_BITS_ADDRESS_REGISTROS)
  ) u_forwarding_B (
    .lee          (i_valid && i_uses_rt),
    .fuente       (i_rt),
    .data_rf      (i_data_B),
    .ex_reg_write (i_ex_reg_write),
    .ex_mem_read  (i_ex_mem_read),
    .ex_rd        (i_ex_rd),
    .ex_data      (i_ex_data),
    .mem_reg_write(i_mem_reg_write),
    .mem_rd       (i_mem_rd),
    .mem_data     (i_mem_data),
    .wb_reg_write (i_wb_reg_write),
    .wb_rd        (i_wb_rd),
    .wb_data      (i_wb_data),
    .data         (dato_B),
    .riesgo       (riesgo_B)
  );

`ifdef FORWARDING_EN
  // After one bubble the load sits in MEM and is bypassed, so a second bubble is never due.
  assign riesgo = (riesgo_A || riesgo_B) && (estado == RUN);
`else
  assign riesgo = riesgo_A || riesgo_B;
`endif

  // A flush kills the instruction, so its hazard neither stalls nor counts.
  assign inserta_burbuja = riesgo && !i_flush;
  assign o_stall         = i_soft_reset && i_enable_etapa && inserta_burbuja;

  always_comb begin
    estado_siguiente = estado;
    carga_instr      = i_valid && !i_flush && !riesgo;
    cuenta_burbuja   = inserta_burbuja;
    case (estado)
      RUN: begin
        if (inserta_burbuja) estado_siguiente = BURBUJA;
      end
      BURBUJA: begin
`ifdef FORWARDING_EN
        estado_siguiente = RUN;
`else
        estado_siguiente = inserta_burbuja ? BURBUJA : RUN;
`endif
      end
      default: estado_siguiente = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    // NOTE: only flops with a defined reset value exist here; no memory needs clearing.
    if (!i_soft_reset) begin
      estado              <= RUN;
      o_valid             <= 1'b0;
      o_reg_write         <= 1'b0;
      o_mem_read          <= 1'b0;
      o_rd                <= '0;
      o_data_A            <= '0;
      o_data_B            <= '0;
      o_imm               <= '0;
      o_contador_burbujas <= '0;
    end else if (i_enable_etapa) begin
      estado <= estado_siguiente;
      if (carga_instr) begin
        o_valid     <= 1'b1;
        o_reg_write <= i_reg_write;
        o_mem_read  <= i_mem_read;
        o_rd        <= i_rd;
        o_data_A    <= dato_A;
        o_data_B    <= dato_B;
        o_imm       <= i_imm;
      end else begin
        // Bubble: control cleared, datapath left as it was.
        o_valid     <= 1'b0;
        o_reg_write <= 1'b0;
        o_mem_read  <= 1'b0;
      end
      if (cuenta_burbuja && (o_contador_burbujas != {CANTIDAD_BITS_CONTADOR{1'b1}}))
        o_contador_burbujas <= o_contador_burbujas + 1'b1;
    end
  end

endmodule

// File: tb/tb_etapa_id_ex.sv
// Self-checking bench for etapa_id_ex: directed hazard scenarios plus a randomized pipeline
// checked against a rule-level reference model; honours FORWARDING_EN like the design.
`timescale 1ns/1ps
module tb_etapa_id_ex;

  logic        i_clock = 1'b0;
  logic        i_soft_reset = 1'b1;
  logic        i_enable_etapa, i_valid, i_flush, i_uses_rt, i_reg_write, i_mem_read;
  logic [4:0]  i_rs, i_rt, i_rd;
  logic [31:0] i_data_A, i_data_B, i_imm;
  logic        i_ex_reg_write, i_ex_mem_read, i_mem_reg_write, i_wb_reg_write;
  logic [4:0]  i_ex_rd, i_mem_rd, i_wb_rd;
  logic [31:0] i_ex_data, i_mem_data, i_wb_data;
  logic        o_stall, o_valid, o_reg_write, o_mem_read;
  logic [4:0]  o_rd;
  logic [31:0] o_data_A, o_data_B, o_imm;
  logic [15:0] o_contador_burbujas;

  int vectores = 0;
  int errores  = 0;

  always #5 i_clock = ~i_clock;

  etapa_id_ex dut (
    .i_clock(i_clock), .i_soft_reset(i_soft_reset), .i_enable_etapa(i_enable_etapa),
    .i_valid(i_valid), .i_flush(i_flush), .i_rs(i_rs), .i_rt(i_rt), .i_uses_rt(i_uses_rt),
    .i_rd(i_rd), .i_reg_write(i_reg_write), .i_mem_read(i_mem_read),
    .i_data_A(i_data_A), .i_data_B(i_data_B), .i_imm(i_imm),
    .i_ex_reg_write(i_ex_reg_write), .i_ex_mem_read(i_ex_mem_read), .i_ex_rd(i_ex_rd),
    .i_ex_data(i_ex_data), .i_mem_reg_write(i_mem_reg_write), .i_mem_rd(i_mem_rd),
    .i_mem_data(i_mem_data), .i_wb_reg_write(i_wb_reg_write), .i_wb_rd(i_wb_rd),
    .i_wb_data(i_wb_data), .o_stall(o_stall), .o_valid(o_valid), .o_reg_write(o_reg_write),
    .o_mem_read(o_mem_read), .o_rd(o_rd), .o_data_A(o_data_A), .o_data_B(o_data_B),
    .o_imm(o_imm), .o_contador_burbujas(o_contador_burbujas)
  );

  task automatic limpiar();
    i_enable_etapa = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_uses_rt = 1'b0;
    i_reg_write = 1'b0; i_mem_read = 1'b0; i_rs = '0; i_rt = '0; i_rd = '0;
    i_data_A = '0; i_data_B = '0; i_imm = '0;
    i_ex_reg_write = 1'b0; i_ex_mem_read = 1'b0; i_ex_rd = '0; i_ex_data = '0;
    i_mem_reg_write = 1'b0; i_mem_rd = '0; i_mem_data = '0;
    i_wb_reg_write = 1'b0; i_wb_rd = '0; i_wb_data = '0;
  endtask

  // Advance to just after the next rising edge.
  task automatic flanco();
    @(posedge i_clock);
    #1;
  endtask

  task automatic aplicar_reset();
    flanco();
    limpiar();
    i_soft_reset = 1'b0;
    #2;
    i_soft_reset = 1'b1;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] a,
                       input logic [31:0] b);
    i_valid = 1'b1; i_rs = rs; i_rt = rt; i_uses_rt = 1'b1; i_rd = 5'd4;
    i_reg_write = 1'b1; i_mem_read = 1'b0; i_data_A = a; i_data_B = b; i_imm = 32'h5;
  endtask

  task automatic test_reset();
    limpiar();
    instr(5'd2, 5'd3, 32'hFFFF_FFFF, 32'h1);
    i_ex_reg_write = 1'b1; i_ex_mem_read = 1'b1; i_ex_rd = 5'd2;
    #1 i_soft_reset = 1'b0;
    #2;
    vectores++;
    if (o_stall !== 1'b0) begin errores++; $display("FAIL reset_stall: got %b want 0", o_stall); end
    flanco();
    vectores++;
    if ({o_valid, o_reg_write, o_mem_read, o_rd, o_data_A, o_data_B, o_imm, o_contador_burbujas} !== '0) begin
      errores++; $display("FAIL reset_outputs: valid=%b data_A=%h cnt=%0d want all 0", o_valid, o_data_A, o_contador_burbujas);
    end
    i_soft_reset = 1'b1;
  endtask

  task automatic test_load_use();
    aplicar_reset();
    instr(5'd2, 5'd3, 32'h1111, 32'h2222);
    i_ex_reg_write = 1'b1; i_ex_mem_read = 1'b1; i_ex_rd = 5'd2;
    #2;
    vectores++;
    if (o_stall !== 1'b1) begin errores++; $display("FAIL load_use_stall: got %b want 1", o_stall); end
    flanco();
    vectores++;
    if (o_valid !== 1'b0 || o_contador_burbujas !== 16'd1) begin
      errores++; $display("FAIL load_use_bubble: valid=%b cnt=%0d want 0/1", o_valid, o_contador_burbujas);
    end
    i_ex_reg_write = 1'b0; i_ex_mem_read = 1'b0;
    i_mem_reg_write = 1'b1; i_mem_rd = 5'd2; i_mem_data = 32'h1234;
`ifndef FORWARDING_EN
    // Without bypass the load is waited out until it has left WB.
    #2;
    vectores++;
    if (o_stall !== 1'b1) begin errores++; $display("FAIL load_use_mem_stall: got %b want 1", o_stall); end
    flanco();
    i_mem_reg_write = 1'b0;
    i_wb_reg_write = 1'b1; i_wb_rd = 5'd2; i_wb_data = 32'h1234;
    #2;
    vectores++;
    if (o_stall !== 1'b1) begin errores++; $display("FAIL load_use_wb_stall: got %b want 1", o_stall); end
    flanco();
    i_wb_reg_write = 1'b0; i_data_A = 32'h1234;
`endif
    #2;
    vectores++;
    if (o_stall !== 1'b0) begin errores++; $display("FAIL load_use_release: got %b want 0", o_stall); end
    flanco();
    vectores++;
    if (o_valid !== 1'b1 || o_data_A !== 32'h1234 || o_data_B !== 32'h2222) begin
      errores++; $display("FAIL load_use_issue: valid=%b A=%h B=%h want 1/00001234/00002222", o_valid, o_data_A, o_data_B);
    end
    vectores++;
`ifdef FORWARDING_EN
    if (o_contador_burbujas !== 16'd1) begin errores++; $display("FAIL load_use_count: got %0d want 1", o_contador_burbujas); end
`else
    if (o_contador_burbujas !== 16'd3) begin errores++; $display("FAIL load_use_count: got %0d want 3", o_contador_burbujas); end
`endif
  endtask

  task automatic test_prioridad();
    aplicar_reset();
    instr(5'd5, 5'd6, 32'h77, 32'h88);
    i_ex_reg_write = 1'b1; i_ex_rd = 5'd5; i_ex_data = 32'hAA;
    i_mem_reg_write = 1'b1; i_mem_rd = 5'd5; i_mem_data = 32'hBB;
    i_wb_reg_write = 1'b1; i_wb_rd = 5'd6; i_wb_data = 32'hCC;
    #2;
    vectores++;
`ifdef FORWARDING_EN
    if (o_stall !== 1'b0) begin errores++; $display("FAIL prio_stall: got %b want 0", o_stall); end
    flanco();
    vectores++;
    if (o_data_A !== 32'hAA || o_data_B !== 32'hCC) begin
      errores++; $display("FAIL prio_ex_wb: A=%h B=%h want aa/cc", o_data_A, o_data_B);
    end
    i_ex_reg_write = 1'b0; i_mem_rd = 5'd6; i_mem_data = 32'hDD;
    #2;
    flanco();
    vectores++;
    if (o_data_A !== 32'h77 || o_data_B !== 32'hDD || o_valid !== 1'b1) begin
      errores++; $display("FAIL prio_mem_rf: A=%h B=%h valid=%b want 77/dd/1", o_data_A, o_data_B, o_valid);
    end
`else
    if (o_stall !== 1'b1) begin errores++; $display("FAIL prio_stall: got %b want 1", o_stall); end
    flanco();
    vectores++;
    if (o_valid !== 1'b0) begin errores++; $display("FAIL prio_bubble: valid=%b want 0", o_valid); end
`endif
  endtask

  task automatic test_registro_cero();
    aplicar_reset();
    instr(5'd0, 5'd0, 32'h0, 32'h99);
    i_ex_reg_write = 1'b1; i_ex_rd = 5'd0; i_ex_data = 32'h55;
    i_mem_reg_write = 1'b1; i_mem_rd = 5'd0; i_mem_data = 32'h66;
    #2;
    vectores++;
    if (o_stall !== 1'b0) begin errores++; $display("FAIL reg0_stall: got %b want 0", o_stall); end
    flanco();
    vectores++;
    if (o_valid !== 1'b1 || o_data_A !== 32'h0 || o_data_B !== 32'h99) begin
      errores++; $display("FAIL reg0_data: valid=%b A=%h B=%h want 1/0/99", o_valid, o_data_A, o_data_B);
    end
  endtask

  task automatic test_flush_riesgo();
    aplicar_reset();
    instr(5'd1, 5'd3, 32'hDEAD, 32'h1);
    #2 flanco();
    instr(5'd2, 5'd3, 32'h1, 32'h1);
    i_ex_reg_write = 1'b1; i_ex_mem_read = 1'b1; i_ex_rd = 5'd2;
    #2 flanco();
    vectores++;
    if (o_valid !== 1'b0 || o_data_A !== 32'hDEAD || o_contador_burbujas !== 16'd1) begin
      errores++; $display("FAIL bubble_hold: valid=%b A=%h cnt=%0d want 0/dead/1", o_valid, o_data_A, o_contador_burbujas);
    end
    i_ex_reg_write = 1'b0; i_ex_mem_read = 1'b0; i_valid = 1'b0;
    #2 flanco();
    vectores++;
    if (o_valid !== 1'b0 || o_contador_burbujas !== 16'd1) begin
      errores++; $display("FAIL invalid_bubble: valid=%b cnt=%0d want 0/1", o_valid, o_contador_burbujas);
    end
    instr(5'd2, 5'd3, 32'h1, 32'h1);
    i_flush = 1'b1;
    i_ex_reg_write = 1'b1; i_ex_mem_read = 1'b1; i_ex_rd = 5'd2;
    #2;
    vectores++;
    if (o_stall !== 1'b0) begin errores++; $display("FAIL flush_stall: got %b want 0", o_stall); end
    flanco();
    vectores++;
    if (o_valid !== 1'b0 || o_data_A !== 32'hDEAD || o_contador_burbujas !== 16'd1) begin
      errores++; $display("FAIL flush_bubble: valid=%b A=%h cnt=%0d want 0/dead/1", o_valid, o_data_A, o_contador_burbujas);
    end
  endtask

  task automatic test_reset_en_burbuja();
    aplicar_reset();
    instr(5'd1, 5'd3, 32'hAAAA_5555, 32'h1);
    i_mem_read = 1'b1; i_rd = 5'd9;
    #2 flanco();
    instr(5'd2, 5'd3, 32'h1, 32'h1);
    i_ex_reg_write = 1'b1; i_ex_mem_read = 1'b1; i_ex_rd = 5'd2;
    #2 flanco();
    #2 i_soft_reset = 1'b0;
    #1;
    vectores++;
    if ({o_stall, o_valid, o_reg_write, o_mem_read, o_rd, o_data_A, o_data_B, o_imm, o_contador_burbujas} !== '0) begin
      errores++; $display("FAIL reset_mid_stall: stall=%b A=%h cnt=%0d want all 0", o_stall, o_data_A, o_contador_burbujas);
    end
    i_soft_reset = 1'b1;
    #1;
    vectores++;
    if (o_stall !== 1'b1) begin errores++; $display("FAIL reset_state_run: stall=%b want 1", o_stall); end
    flanco();
    i_ex_reg_write = 1'b0; i_ex_mem_read = 1'b0;
    i_data_A = 32'h1357;
    #2 flanco();
    for (int k = 0; k < 3; k++) begin
      i_enable_etapa = 1'b0;
      i_ex_reg_write = 1'b1; i_ex_mem_read = 1'b1; i_data_A = $urandom; i_valid = k[0];
      #2;
      vectores++;
      if (o_stall !== 1'b0) begin errores++; $display("FAIL enable_stall: cycle %0d got %b want 0", k, o_stall); end
      flanco();
      vectores++;
      if (o_valid !== 1'b1 || o_data_A !== 32'h1357 || o_contador_burbujas !== 16'd1) begin
        errores++; $display("FAIL enable_hold: cycle %0d valid=%b A=%h cnt=%0d want 1/1357/1", k, o_valid, o_data_A, o_contador_burbujas);
      end
    end
  endtask

  task automatic test_productor_alu();
    aplicar_reset();
    instr(5'd7, 5'd0, 32'h0, 32'h0);
    i_ex_reg_write = 1'b1; i_ex_rd = 5'd7; i_ex_data = 32'hABCD;
`ifndef FORWARDING_EN
    for (int k = 0; k < 3; k++) begin
      i_ex_reg_write = (k == 0); i_mem_reg_write = (k == 1); i_wb_reg_write = (k == 2);
      i_mem_rd = 5'd7; i_wb_rd = 5'd7;
      #2;
      vectores++;
      if (o_stall !== 1'b1) begin errores++; $display("FAIL alu_prod_stall: bubble %0d got %b want 1", k, o_stall); end
      flanco();
    end
    i_wb_reg_write = 1'b0; i_data_A = 32'hABCD;
`endif
    #2;
    vectores++;
    if (o_stall !== 1'b0) begin errores++; $display("FAIL alu_prod_issue_stall: got %b want 0", o_stall); end
    flanco();
    vectores++;
`ifdef FORWARDING_EN
    if (o_valid !== 1'b1 || o_data_A !== 32'hABCD || o_contador_burbujas !== 16'd0) begin
      errores++; $display("FAIL alu_prod_issue: valid=%b A=%h cnt=%0d want 1/abcd/0", o_valid, o_data_A, o_contador_burbujas);
    end
`else
    if (o_valid !== 1'b1 || o_data_A !== 32'hABCD || o_contador_burbujas !== 16'd3) begin
      errores++; $display("FAIL alu_prod_issue: valid=%b A=%h cnt=%0d want 1/abcd/3", o_valid, o_data_A, o_contador_burbujas);
    end
`endif
  endtask

  // Reference rules for one source operand: value it should carry and whether it must wait.
  function automatic void modelo_operando(input logic lee, input logic [4:0] s,
                                          input logic [31:0] rf, output logic [31:0] v,
                                          output logic hz);
    logic en_ex, en_mem, en_wb;
    en_ex  = (s != 0) && i_ex_reg_write  && (i_ex_rd  == s);
    en_mem = (s != 0) && i_mem_reg_write && (i_mem_rd == s);
    en_wb  = (s != 0) && i_wb_reg_write  && (i_wb_rd  == s);
    v = rf;
`ifdef FORWARDING_EN
    if (en_ex && !i_ex_mem_read) v = i_ex_data;
    else if (en_mem)             v = i_mem_data;
    else if (en_wb)              v = i_wb_data;
    hz = lee && en_ex && i_ex_mem_read;
`else
    hz = lee && (en_ex || en_mem || en_wb);
`endif
  endfunction

  task automatic test_aleatorio();
    logic        m_valid, m_rw, m_mr, mem_rw, wb_rw, hz_a, hz_b, hz;
    logic [4:0]  m_rd, mem_rd, wb_rd;
    logic [31:0] m_a, m_b, m_imm, v_a, v_b;
    int          m_cnt;
    aplicar_reset();
    {m_valid, m_rw, m_mr, mem_rw, wb_rw} = '0;
    {m_rd, mem_rd, wb_rd} = '0;
    {m_a, m_b, m_imm} = '0;
    m_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      // EX carries what this stage latched last; MEM and WB trail behind it.
      i_ex_reg_write = m_rw; i_ex_mem_read = m_mr; i_ex_rd = m_rd; i_ex_data = $urandom;
      i_mem_reg_write = mem_rw; i_mem_rd = mem_rd; i_mem_data = $urandom;
      i_wb_reg_write = wb_rw; i_wb_rd = wb_rd; i_wb_data = $urandom;
      i_enable_etapa = ($urandom_range(0, 9) != 0);
      i_valid = ($urandom_range(0, 6) != 0);
      i_flush = ($urandom_range(0, 9) == 0);
      i_rs = 5'($urandom_range(0, 7)); i_rt = 5'($urandom_range(0, 7)); i_rd = 5'($urandom_range(0, 7));
      i_uses_rt = $urandom_range(0, 1); i_reg_write = ($urandom_range(0, 3) != 0);
      i_mem_read = ($urandom_range(0, 2) == 0);
      i_data_A = $urandom; i_data_B = $urandom; i_imm = $urandom;
      modelo_operando(i_valid, i_rs, i_data_A, v_a, hz_a);
      modelo_operando(i_valid && i_uses_rt, i_rt, i_data_B, v_b, hz_b);
      hz = hz_a || hz_b;
      #2;
      vectores++;
      if (o_stall !== (i_enable_etapa && hz && !i_flush)) begin
        errores++; $display("FAIL rand_stall: vec %0d got %b want %b", n, o_stall, i_enable_etapa && hz && !i_flush);
      end
      if (i_enable_etapa) begin
        wb_rw = mem_rw; wb_rd = mem_rd;
        mem_rw = m_rw; mem_rd = m_rd;
        if (i_valid && !i_flush && !hz) begin
          m_valid = 1'b1; m_rw = i_reg_write; m_mr = i_mem_read; m_rd = i_rd;
          m_a = v_a; m_b = v_b; m_imm = i_imm;
        end else begin
          m_valid = 1'b0; m_rw = 1'b0; m_mr = 1'b0;
        end
        if (hz && !i_flush && m_cnt < 65535) m_cnt++;
      end
      flanco();
      vectores++;
      if ({o_valid, o_reg_write, o_mem_read} !== {m_valid, m_rw, m_mr}) begin
        errores++; $display("FAIL rand_ctrl: vec %0d got %b%b%b want %b%b%b", n, o_valid, o_reg_write, o_mem_read, m_valid, m_rw, m_mr);
      end
      vectores++;
      if (o_data_A !== m_a || o_data_B !== m_b || o_imm !== m_imm) begin
        errores++; $display("FAIL rand_data: vec %0d got %h %h %h want %h %h %h", n, o_data_A, o_data_B, o_imm, m_a, m_b, m_imm);
      end
      vectores++;
      if (o_contador_burbujas !== 16'(m_cnt)) begin
        errores++; $display("FAIL rand_count: vec %0d got %0d want %0d", n, o_contador_burbujas, m_cnt);
      end
      if (m_valid) begin
        vectores++;
        if (o_rd !== m_rd) begin errores++; $display("FAIL rand_rd: vec %0d got %0d want %0d", n, o_rd, m_rd); end
      end
    end
  endtask

  initial begin
    limpiar();
    test_reset();
    test_load_use();
    test_prioridad();
    test_registro_cero();
    test_flush_riesgo();
    test_reset_en_burbuja();
    test_productor_alu();
    test_aleatorio();
    $display("== %0d vectors applied, %0d miscompares ==", vectores, errores);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
